// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle: instruction-memory side words plus flush/stall
// control in, decoded instruction out. The slave modport is the buffer itself.
interface fetch_decode_buffer_if;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic [4:0]  out_opcode;
  logic [2:0]  out_rsrc;
  logic [2:0]  out_rdst;

  modport master (
    output in_instr, in_valid, flush, stall,
    input  in_ready, out_valid, out_instr, out_imm, out_opcode, out_rsrc, out_rdst
  );

  modport slave (
    input  in_instr, in_valid, flush, stall,
    output in_ready, out_valid, out_instr, out_imm, out_opcode, out_rsrc, out_rdst
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Fetch/decode buffer: 2-entry word FIFO feeding a small assembler that pairs an
// IMM_OPC opcode word with the immediate word following it.
// Optional build macro DECODE_PERF_EN adds stall_cycles/flush_count counters.
module fetch_decode_buffer #(
  parameter logic [4:0] IMM_OPC = 5'd12
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_buffer_if.slave  bus
`ifdef DECODE_PERF_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_count
`endif
);

  typedef enum logic {S_OP, S_IMM} state_t;

  logic [15:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  state_t      state;
  logic [15:0] hold;
  logic        out_valid_q;
  logic [15:0] out_instr_q;
  logic [15:0] out_imm_q;

  logic        in_ready;
  logic        slot_free;
  logic        push;
  logic        pop;
  logic [15:0] head;

  assign in_ready  = (count < 2'd2);
  assign slot_free = !out_valid_q || !bus.stall;
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = (count != 2'd0) && slot_free && !bus.flush;
  assign head      = mem[rd_ptr];

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_imm    = out_imm_q;
  assign bus.out_opcode = out_instr_q[15:11];
  assign bus.out_rsrc   = out_instr_q[10:8];
  assign bus.out_rdst   = out_instr_q[7:5];

  // Word FIFO storage, pointers and occupancy; flush empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_instr;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Opcode/immediate assembly FSM with registered decode outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_OP;
      hold        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_imm_q   <= '0;
    end else if (bus.flush) begin
      state       <= S_OP;
      hold        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_imm_q   <= '0;
    end else if (pop) begin
      case (state)
        S_OP: begin
          if (head[15:11] != IMM_OPC) begin
            out_instr_q <= head;
            out_imm_q   <= '0;
            out_valid_q <= 1'b1;
          end else begin
            hold        <= head;
            out_valid_q <= 1'b0;
            state       <= S_IMM;
          end
        end
        S_IMM: begin
          out_instr_q <= hold;
          out_imm_q   <= head;
          out_valid_q <= 1'b1;
          state       <= S_OP;
        end
        default: state <= S_OP;
      endcase
    end else if (out_valid_q && !bus.stall) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_PERF_EN
  // Stall/flush event counters; wrap naturally, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (bus.stall && out_valid_q) stall_cycles <= stall_cycles + 16'd1;
      if (bus.flush)                flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: a vector table for steady-state
// behaviour plus hand sequences for flush, async reset and perf counters.
module tb_fetch_decode_buffer;

  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;

  fetch_decode_buffer_if bus();

`ifdef DECODE_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  fetch_decode_buffer #(.IMM_OPC(5'd12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DECODE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        vld;
    logic        stall;
    logic        flush;
    logic        e_rdy;
    logic        e_vld;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic vld, input logic stall, input logic flush);
    bus.in_instr = instr;
    bus.in_valid = vld;
    bus.stall    = stall;
    bus.flush    = flush;
  endtask

  initial begin
    logic [15:0] ei;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    drive(16'h0, 1'b0, 1'b0, 1'b0);

    //            instr     vld   stall flush  rdy   vld   out_instr out_imm
    vt[0]  = '{16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000};
    vt[2]  = '{16'h6000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[3]  = '{16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[4]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6000, 16'hBEEF};
    vt[5]  = '{16'hA001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h6000, 16'hBEEF};
    vt[6]  = '{16'hA002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h6000, 16'hBEEF};
    vt[7]  = '{16'hA003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h6000, 16'hBEEF};
    vt[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA001, 16'h0000};
    vt[9]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA002, 16'h0000};
    vt[10] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[11] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[12] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000};
    vt[13] = '{16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000};
    vt[14] = '{16'h2222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vt[15] = '{16'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h0000};
    vt[16] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 16'h0000};
    vt[17] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[18] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};

    // Reset state
    tick();
    tick();
    chk("rst out_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("rst in_ready",  {15'b0, bus.in_ready},  16'h1);
    chk("rst out_instr", bus.out_instr, 16'h0);
    chk("rst out_imm",   bus.out_imm,   16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].instr, vt[i].vld, vt[i].stall, vt[i].flush);
      tick();
      chk($sformatf("v%0d in_ready", i),  {15'b0, bus.in_ready},  {15'b0, vt[i].e_rdy});
      chk($sformatf("v%0d out_valid", i), {15'b0, bus.out_valid}, {15'b0, vt[i].e_vld});
      if (vt[i].e_vld) begin
        ei = vt[i].e_instr;
        chk($sformatf("v%0d out_instr", i),  bus.out_instr, ei);
        chk($sformatf("v%0d out_imm", i),    bus.out_imm,   vt[i].e_imm);
        chk($sformatf("v%0d out_opcode", i), {11'b0, bus.out_opcode}, {11'b0, ei[15:11]});
        chk($sformatf("v%0d out_rsrc", i),   {13'b0, bus.out_rsrc},   {13'b0, ei[10:8]});
        chk($sformatf("v%0d out_rdst", i),   {13'b0, bus.out_rdst},   {13'b0, ei[7:5]});
      end
    end

    // Explicit decode of 16'h1234 (opcode 2, rsrc 2, rdst 1)
    drive(16'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("dec1234 opcode", {11'b0, bus.out_opcode}, 16'h0002);
    chk("dec1234 rsrc",   {13'b0, bus.out_rsrc},   16'h0002);
    chk("dec1234 rdst",   {13'b0, bus.out_rdst},   16'h0001);
    tick();

    // Flush while waiting for an immediate with a word pending
    drive(16'h6000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h7001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl pre out_valid", {15'b0, bus.out_valid}, 16'h0);
    drive(16'h7002, 1'b1, 1'b0, 1'b1);
    tick();
    chk("fl out_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("fl in_ready",  {15'b0, bus.in_ready},  16'h1);
    chk("fl out_instr", bus.out_instr, 16'h0);
    chk("fl out_imm",   bus.out_imm,   16'h0);
    drive(16'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl post push out_valid", {15'b0, bus.out_valid}, 16'h0);
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl S_OP out_valid", {15'b0, bus.out_valid}, 16'h1);
    chk("fl S_OP out_instr", bus.out_instr, 16'h1234);
    chk("fl S_OP out_imm",   bus.out_imm,   16'h0);
    tick();
    chk("fl no leftover", {15'b0, bus.out_valid}, 16'h0);

    // Asynchronous reset between edges
    drive(16'h5678, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar pre out_valid", {15'b0, bus.out_valid}, 16'h1);
    #2 rst = 1'b0;
    #1;
    chk("ar out_valid", {15'b0, bus.out_valid}, 16'h0);
    chk("ar in_ready",  {15'b0, bus.in_ready},  16'h1);
    chk("ar out_instr", bus.out_instr, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Word captured before a reset must not survive it
    drive(16'h9999, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("ar2 no survivor", {15'b0, bus.out_valid}, 16'h0);
    drive(16'h4321, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar2 resume valid", {15'b0, bus.out_valid}, 16'h1);
    chk("ar2 resume instr", bus.out_instr, 16'h4321);

`ifdef DECODE_PERF_EN
    // Five stalled valid cycles, then two flushes
    drive(16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("perf stall_cycles", stall_cycles, 16'd5);
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("perf flush_count", flush_count, 16'd2);
    chk("perf stall_cycles held", stall_cycles, 16'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL have parameter IMM_OPC, default 5'd12, meaning the opcode (instr[15:11]) whose instruction is followed by one 16-bit immediate word.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_instr  input  16  word from instruction memory.
REQ-005 SHALL have port in_valid  input  1  in_instr valid this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a word (count<2).
REQ-007 SHALL have port flush  input  1  taken jump/call; discard everything held.
REQ-008 SHALL have port stall  input  1  downstream hazard; hold current output.
REQ-009 SHALL have port out_valid  output  1  out_* holds a complete instruction.
REQ-010 SHALL have port out_instr  output  16  opcode word.
REQ-011 SHALL have port out_imm  output  16  immediate word (0 when none).
REQ-012 SHALL have port out_opcode  output  5  out_instr[15:11].
REQ-013 SHALL have port out_rsrc  output  3  out_instr[10:8].
REQ-014 SHALL have port out_rdst  output  3  out_instr[7:5].

Function
REQ-015 SHALL hold a 2-entry FIFO of 16-bit words; a word is written on a posedge where in_valid && in_ready && !flush.
REQ-016 SHALL drive in_ready = (count < 2), from registered count; no write when full even if a pop occurs the same cycle.
REQ-017 SHALL define slot_free = !out_valid || !stall; the output is consumed on a posedge where out_valid && !stall.
REQ-018 SHALL run FSM with states S_OP (awaiting opcode word) and S_IMM (opcode word held, awaiting immediate).
REQ-019 In S_OP with FIFO non-empty and slot_free: pop head; if head[15:11] != IMM_OPC load out_instr=head, out_imm=0, out_valid=1; else store head in hold register, out_valid=0, go S_IMM.
REQ-020 In S_IMM with FIFO non-empty and slot_free: pop head, load out_instr=hold, out_imm=head, out_valid=1, go S_OP.
REQ-021 When no pop occurs and output is consumed, out_valid SHALL go 0; when stall && out_valid, all out_* SHALL hold.
REQ-022 Latency: word written at edge N SHALL appear on out_* after edge N+1 (single-word) if slot_free; immediate pair after the edge popping the second word.
REQ-023 At most one pop per cycle; an all-zero word (bubble) SHALL pass through as an ordinary instruction.
REQ-024 flush SHALL take priority: on that edge count=0, FSM=S_OP, hold=0, out_valid=0, out_instr=0, out_imm=0, in_valid ignored.
REQ-025 out_opcode/out_rsrc/out_rdst SHALL be pure slices of registered out_instr.

Reset
REQ-026 While rst=0: count=0, FSM=S_OP, hold=0, out_valid=0, out_instr=0, out_imm=0, in_ready=1; counters (REQ-028) =0.
REQ-027 Reset deassertion mid-operation SHALL resume from reset state; no word captured before deassertion survives.

Configuration
REQ-028 With DECODE_PERF_EN defined, SHALL add outputs stall_cycles[15:0] (increments on each posedge with stall && out_valid) and flush_count[15:0] (increments on each flush), both wrapping at 16'hFFFF->0 and cleared by flush? no -- cleared only by reset.
REQ-029 Without DECODE_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset release, push 16'h1234 (opcode 2) with stall=0 -> after next edge out_valid=1, out_instr=16'h1234, out_imm=0, out_rdst=3'b001.
REQ-031 Push 16'h6000 (opcode 12) then 16'hBEEF -> single valid output out_instr=16'h6000, out_imm=16'hBEEF; no intermediate out_valid.
REQ-032 Hold stall=1 with valid output, push 3 words -> in_ready=0 after second accept, third not accepted, out_* unchanged; release stall -> words emerge in order.
REQ-033 Full FIFO in S_IMM, assert flush one cycle with in_valid=1 -> next edge out_valid=0, in_ready=1, FSM S_OP, flushed word absent.
REQ-034 Assert rst=0 asynchronously between edges while out_valid=1 -> out_valid=0 immediately, without a clock edge.
REQ-035 DECODE_PERF_EN defined, 5 stalled valid cycles and 2 flushes -> stall_cycles=5, flush_count=2.
